// File: rtl/fifo_rd_stream_pkg.sv
// Shared state type, read-latency limits and pointer sizing for the fifo_rd_stream block.
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // One extra wrap bit lets a full buffer be told apart from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular skid buffer for fifo_rd_stream: push/pop/clear with occupancy output.
module fifo_rd_skid
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    ptr_diff;
    logic [WIDTH-1:0] mem [DEPTH];

    assign ptr_diff  = wr_ptr - rd_ptr;
    assign level     = LW'(ptr_diff);
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Storage is reset too so the head word reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && (level == LW'(DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain controller turning a non-FWFT FIFO read port into a valid/ready stream.
// Define FIFO_RD_STREAM_ERRCNT_EN to add the saturating rderr_cnt read-error counter.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter int RD_LAT     = 2,
    parameter int SKID_DEPTH = 4,
    parameter int RST_HOLD   = 5
) (
    input  logic                              rd_clk,
    input  logic                              rstn,
    input  logic [WIDTH-1:0]                  fifo_dout,
    input  logic                              fifo_empty,
    input  logic                              fifo_rderr,
    output logic                              fifo_rd_en,
    input  logic                              flush,
    output logic                              m_valid,
    output logic [WIDTH-1:0]                  m_data,
    input  logic                              m_ready,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   level,
`ifdef FIFO_RD_STREAM_ERRCNT_EN
    output logic [15:0]                       rderr_cnt,
`endif
    output logic                              busy
);

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int CW = $clog2(SKID_DEPTH + RD_LAT + 1);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || SKID_DEPTH < RD_LAT + 1 ||
        (SKID_DEPTH & (SKID_DEPTH - 1)) != 0) begin : g_bad_params
        $error("fifo_rd_stream: illegal RD_LAT / SKID_DEPTH combination");
    end

    state_t            state;
    state_t            next_state;
    logic [HW-1:0]     hold_cnt;
    logic              hold_done;
    logic [RD_LAT-1:0] pipe_q;
    logic              ret_valid;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     occupancy;
    logic              skid_clear;
    logic              skid_push;
    logic              skid_pop;

    assign hold_done = (hold_cnt >= HW'(RST_HOLD - 1));
    assign ret_valid = pipe_q[RD_LAT-1];
    assign inflight  = CW'($countones(pipe_q));
    assign occupancy = inflight + CW'(level);
    assign m_valid   = (level != '0);

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_HOLD;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt <= '0;
        end else if (state == ST_HOLD) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // Each bit marks a read whose data is still travelling through the primitive.
    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= RD_LAT'({pipe_q, fifo_rd_en});
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_HOLD:  if (hold_done) next_state = ST_RUN;
            ST_RUN:   if (flush) next_state = ST_FLUSH;
            ST_FLUSH: if (!flush && fifo_empty && (inflight == '0)) next_state = ST_RUN;
            default:  next_state = ST_HOLD;
        endcase
    end

    // Clearing starts on the request cycle so the buffer is already empty once FLUSH is entered.
    always_comb begin
        fifo_rd_en = 1'b0;
        busy       = 1'b1;
        skid_clear = 1'b0;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        unique case (state)
            ST_RUN: begin
                busy       = 1'b0;
                fifo_rd_en = !fifo_empty && (occupancy < CW'(SKID_DEPTH));
                skid_clear = flush;
                skid_push  = ret_valid && !flush;
                skid_pop   = m_valid && m_ready && !flush;
            end
            ST_FLUSH: begin
                fifo_rd_en = !fifo_empty;
                skid_clear = 1'b1;
            end
            default: begin
            end
        endcase
    end

    fifo_rd_skid #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (rd_clk),
        .rst_n     (rstn),
        .clear     (skid_clear),
        .push      (skid_push),
        .push_data (fifo_dout),
        .pop       (skid_pop),
        .head_data (m_data),
        .level     (level)
    );

`ifdef FIFO_RD_STREAM_ERRCNT_EN
    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            rderr_cnt <= '0;
        end else if ((state == ST_RUN) && flush) begin
            rderr_cnt <= '0;
        end else if (fifo_rderr && (rderr_cnt != 16'hFFFF)) begin
            rderr_cnt <= rderr_cnt + 16'd1;
        end
    end
`else
    logic unused_rderr;
    assign unused_rderr = fifo_rderr;
`endif

endmodule
